// File: rtl/lcg_predict.sv
// LCG sequence predictor: regenerates x' = (x*a + c) mod m from a recovered seed and
// streams the predicted values (after an optional skip) over a valid/ready port.
module lcg_predict #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     MODULUS,
    input  logic [W-1:0]     MULTIPLIER,
    input  logic [W-1:0]     INCREMENT,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [W-1:0]     seed,
    input  logic [CNT_W-1:0] skip,
    input  logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_value,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             error
);

    localparam int PW = 2*W + 1;
    localparam int BW = $clog2(PW);
    localparam logic [BW-1:0]    LAST_BIT = BW'(PW - 1);
    localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_MOD,
        S_EMIT
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]     x, m_q, a_q, c_q;
    logic [CNT_W-1:0] skip_q, count_q, skipped, idx;
    logic [PW-1:0]    p, prod;
    logic [W-1:0]     r, r_nx;
    logic [W:0]       r_sh;
    logic [BW-1:0]    bit_cnt;
    logic             err_q;
    logic             accept, last_bit, more_skip, final_beat;

    assign accept     = seed_valid && (state == S_IDLE);
    assign last_bit   = (bit_cnt == LAST_BIT);
    assign more_skip  = (skipped < skip_q);
    assign final_beat = (idx == count_q - CNT_ONE);

    // Full-width product: no truncation before the reduction.
    assign prod = PW'(x) * PW'(a_q) + PW'(c_q);

    // One restoring step: the partial remainder is < m, so the shifted value fits W+1 bits
    // and after a conditional subtract fits back into W bits.
    assign r_sh = {r, p[PW-1]};
    assign r_nx = (r_sh >= {1'b0, m_q}) ? W'(r_sh - {1'b0, m_q}) : r_sh[W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                // Zero modulus or zero count: job is latched but nothing is generated.
                if (accept && (MODULUS != '0) && (count != '0))
                    state_nx = S_MUL;
            end
            S_MUL:  state_nx = S_MOD;
            S_MOD: begin
                if (last_bit)
                    state_nx = more_skip ? S_MUL : S_EMIT;
            end
            S_EMIT: begin
                if (out_ready)
                    state_nx = final_beat ? S_IDLE : S_MUL;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            x       <= '0;
            m_q     <= '0;
            a_q     <= '0;
            c_q     <= '0;
            skip_q  <= '0;
            count_q <= '0;
            skipped <= '0;
            idx     <= '0;
            p       <= '0;
            r       <= '0;
            bit_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x       <= seed;
                        m_q     <= MODULUS;
                        a_q     <= MULTIPLIER;
                        c_q     <= INCREMENT;
                        skip_q  <= skip;
                        count_q <= count;
                        skipped <= '0;
                        idx     <= '0;
                        err_q   <= (MODULUS == '0);
                    end
                end
                S_MUL: begin
                    p       <= prod;
                    r       <= '0;
                    bit_cnt <= '0;
                end
                S_MOD: begin
                    p       <= {p[PW-2:0], 1'b0};
                    r       <= r_nx;
                    bit_cnt <= bit_cnt + BIT_ONE;
                    if (last_bit) begin
                        x <= r_nx;
                        if (more_skip)
                            skipped <= skipped + CNT_ONE;
                    end
                end
                S_EMIT: begin
                    if (out_ready && !final_beat)
                        idx <= idx + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign seed_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_EMIT);
    // x only changes outside EMIT, so the beat holds steady under backpressure.
    assign out_value  = x;
    assign out_index  = idx;
    assign out_last   = out_valid && final_beat;
    assign error      = err_q;

endmodule
